// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_sub
//  Description : Digit-serial adder/subtractor. Computes a WIDTH-bit
//                x + y + cin or x - y - cin, processing DIGIT bits per clock.
//                It produces a sum, carry-out, signed overflow and zero flag
//                and uses a start/busy/done handshake.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset
//                start  - request an operation (honoured when busy=0)
//                sub    - 0: add, 1: subtract
//                x, y   - operands, sampled on the accepting edge
//                cin    - carry-in (add) / borrow-in (subtract)
//                busy   - operation in progress
//                done   - one-cycle completion pulse
//                z      - result register
//                cout   - carry out of MSB (subtract: 1 = no borrow)
//                oflow  - two's-complement overflow
//                zero   - z == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
  parameter int WIDTH = 9,
  parameter int DIGIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             oflow,
  output logic             zero
);

  localparam int c_n  = WIDTH / DIGIT;
  localparam int c_cw = $clog2(c_n + 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("serial_add_sub: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [c_cw-1:0]  r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_oflow;
  logic             r_zero;

  logic [DIGIT:0]   w_sum;
  logic [DIGIT-1:0] w_s;
  logic             w_c;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_next_res;
  logic             w_last;

  // One DIGIT-bit ripple step over the low digit of the operand registers.
  assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_carry);
  assign w_s   = w_sum[DIGIT-1:0];
  assign w_c   = w_sum[DIGIT];

  // Carry into the top bit of this digit, recovered from the sum bit. On the
  // last digit this is the carry into bit WIDTH-1 (the carry register itself
  // when DIGIT=1).
  assign w_cmsb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_s[DIGIT-1];

  // Result digits enter at the top so that after N steps the LSB digit has
  // arrived at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_full
      assign w_next_res = w_s;
    end else begin : g_part
      assign w_next_res = {w_s, r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (r_cnt == c_cw'(c_n - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_z     <= '0;
      r_cout  <= 1'b0;
      r_oflow <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtract is x + ~y + ~cin, folded in once at acceptance.
            r_a     <= x;
            r_b     <= y ^ {WIDTH{sub}};
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_next_res;
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_z     <= w_next_res;
            r_cout  <= w_c;
            r_oflow <= w_cmsb ^ w_c;
            r_zero  <= (w_next_res == '0);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign z     = r_z;
  assign cout  = r_cout;
  assign oflow = r_oflow;
  assign zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_sub
//  Description : Self-checking bench for serial_add_sub. Directed vectors on
//                the default (9,3) instance plus a random sweep on the
//                (9,1), (9,9) and (16,4) instances against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

  logic clk;
  logic rst_n;

  // Default-configuration instance.
  logic       start, sub, cin;
  logic [8:0] x, y;
  logic       busy, done, cout, oflow, zero;
  logic [8:0] z;

  // Sweep instances share one stimulus set.
  logic        sw_start, sw_sub, sw_cin;
  logic [15:0] sw_x, sw_y;
  logic        b1, d1, co1, ov1, zr1;
  logic [8:0]  z1;
  logic        b9, d9, co9, ov9, zr9;
  logic [8:0]  z9;
  logic        b16, d16, co16, ov16, zr16;
  logic [15:0] z16;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_sub #(.WIDTH(9), .DIGIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .x(x), .y(y), .cin(cin),
    .busy(busy), .done(done), .z(z), .cout(cout), .oflow(oflow), .zero(zero)
  );

  serial_add_sub #(.WIDTH(9), .DIGIT(1)) u_w9d1 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .sub(sw_sub), .x(sw_x[8:0]), .y(sw_y[8:0]),
    .cin(sw_cin), .busy(b1), .done(d1), .z(z1), .cout(co1), .oflow(ov1), .zero(zr1)
  );

  serial_add_sub #(.WIDTH(9), .DIGIT(9)) u_w9d9 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .sub(sw_sub), .x(sw_x[8:0]), .y(sw_y[8:0]),
    .cin(sw_cin), .busy(b9), .done(d9), .z(z9), .cout(co9), .oflow(ov9), .zero(zr9)
  );

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .sub(sw_sub), .x(sw_x), .y(sw_y),
    .cin(sw_cin), .busy(b16), .done(d16), .z(z16), .cout(co16), .oflow(ov16), .zero(zr16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation on the default instance; lat = cycles from the
  // accepting edge to done, 0 if done never arrived within the bound.
  task automatic run_op(input logic s, input logic [8:0] xv, input logic [8:0] yv,
                        input logic c, output int lat);
    sub = s; x = xv; y = yv; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_res(input string tag, input int lat, input logic [8:0] ez,
                           input logic ec, input logic eo, input logic ezr);
    check({tag, " latency"}, lat, 3);
    check({tag, " z"}, z, ez);
    check({tag, " cout"}, cout, ec);
    check({tag, " oflow"}, oflow, eo);
    check({tag, " zero"}, zero, ezr);
  endtask

  // Reference: full-width integer sum; overflow from operand/result signs.
  task automatic model(input int w, input logic [15:0] xv, input logic [15:0] yv,
                       input logic c, input logic s,
                       output logic [15:0] zr, output logic co, output logic ov);
    int mask, xm, ym, e;
    mask = (1 << w) - 1;
    xm   = int'(xv) & mask;
    ym   = (s ? ~int'(yv) : int'(yv)) & mask;
    e    = xm + ym + int'(c ^ s);
    zr   = 16'(e & mask);
    co   = e[w];
    ov   = (xm[w-1] == ym[w-1]) && (zr[w-1] != xm[w-1]);
  endtask

  initial begin
    int lat;
    int l1, l9, l16;
    logic [15:0] ez;
    logic ec, eo;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; x = '0; y = '0;
    sw_start = 1'b0; sw_sub = 1'b0; sw_cin = 1'b0; sw_x = '0; sw_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst z", z, 0);
    check("rst cout", cout, 0);
    check("rst oflow", oflow, 0);
    check("rst zero", zero, 1);
    check("rst zero w16", zr16, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on the default configuration.
    run_op(1'b0, 9'h0FF, 9'h001, 1'b0, lat); check_res("add ff+1", lat, 9'h100, 0, 1, 0);
    run_op(1'b1, 9'h005, 9'h007, 1'b0, lat); check_res("sub 5-7", lat, 9'h1FE, 0, 0, 0);
    run_op(1'b1, 9'h007, 9'h005, 1'b0, lat); check_res("sub 7-5", lat, 9'h002, 1, 0, 0);
    run_op(1'b0, 9'h100, 9'h100, 1'b0, lat); check_res("add 100+100", lat, 9'h000, 1, 1, 1);
    run_op(1'b0, 9'h1FF, 9'h000, 1'b1, lat); check_res("add 1ff+cin", lat, 9'h000, 1, 0, 1);
    run_op(1'b1, 9'h005, 9'h002, 1'b1, lat); check_res("sub 5-2-b", lat, 9'h002, 1, 0, 0);

    // Handshake: start while busy is ignored; start in done cycle is taken.
    sub = 1'b0; x = 9'h003; y = 9'h004; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                                 // E
    x = 9'h1AA; y = 9'h055; cin = 1'b1; start = 1'b1;
    check("hs busy E", busy, 1);
    @(posedge clk); #1;                                 // E+1
    start = 1'b0;
    check("hs done E+1", done, 0);
    @(posedge clk); #1;                                 // E+2
    check("hs done E+2", done, 0);
    @(posedge clk); #1;                                 // E+3
    check("hs done E+3", done, 1);
    check("hs busy E+3", busy, 0);
    check("hs z first", z, 9'h007);
    x = 9'h010; y = 9'h020; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                                 // E'
    start = 1'b0;
    check("b2b busy", busy, 1);
    check("b2b done low", done, 0);
    check("b2b hold z0", z, 9'h007);
    @(posedge clk); #1;
    check("b2b hold z1", z, 9'h007);
    @(posedge clk); #1;
    check("b2b hold z2", z, 9'h007);
    check("b2b done E'+2", done, 0);
    @(posedge clk); #1;
    check("b2b done E'+3", done, 1);
    check("b2b z second", z, 9'h030);
    @(posedge clk); #1;
    check("b2b done drop", done, 0);
    check("b2b no queue", busy, 0);
    check("b2b z hold", z, 9'h030);

    // Reset in the middle of an operation.
    sub = 1'b0; x = 9'h0FF; y = 9'h001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                                 // E
    start = 1'b0;
    @(posedge clk); #1;                                 // E+1
    rst_n = 1'b0;
    @(posedge clk); #1;                                 // E+2, reset sampled
    rst_n = 1'b1;
    check("mid-rst busy", busy, 0);
    check("mid-rst done", done, 0);
    check("mid-rst z", z, 0);
    check("mid-rst cout", cout, 0);
    check("mid-rst oflow", oflow, 0);
    check("mid-rst zero", zero, 1);
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) lat = 1;
    end
    check("mid-rst no done", lat, 0);
    run_op(1'b1, 9'h007, 9'h005, 1'b0, lat); check_res("post-rst", lat, 9'h002, 1, 0, 0);

    // Parameter sweep against the reference model.
    for (int i = 0; i < 512; i++) begin
      sw_x = 16'($urandom); sw_y = 16'($urandom);
      sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      if (i == 0) begin sw_x = 16'h0000; sw_y = 16'h0000; sw_cin = 1'b0; sw_sub = 1'b0; end
      sw_start = 1'b1;
      @(posedge clk); #1;
      sw_start = 1'b0;
      l1 = 0; l9 = 0; l16 = 0;
      for (int k = 1; k <= 11; k++) begin
        @(posedge clk); #1;
        if (d1  && l1  == 0) l1  = k;
        if (d9  && l9  == 0) l9  = k;
        if (d16 && l16 == 0) l16 = k;
      end
      check("w9d1 latency", l1, 9);
      check("w9d9 latency", l9, 1);
      check("w16d4 latency", l16, 4);
      model(9, sw_x, sw_y, sw_cin, sw_sub, ez, ec, eo);
      check("w9d1 z", z1, ez);      check("w9d1 cout", co1, ec);
      check("w9d1 oflow", ov1, eo); check("w9d1 zero", zr1, ez == 0);
      check("w9d9 z", z9, ez);      check("w9d9 cout", co9, ec);
      check("w9d9 oflow", ov9, eo); check("w9d9 zero", zr9, ez == 0);
      model(16, sw_x, sw_y, sw_cin, sw_sub, ez, ec, eo);
      check("w16d4 z", z16, ez);      check("w16d4 cout", co16, ec);
      check("w16d4 oflow", ov16, eo); check("w16d4 zero", zr16, ez == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
